// File: rtl/lcd_cmd_driver.sv
// Host-side initiator for the LCD controller command interface: issues one command,
// streams the image RAM on LOAD, and collects the returned window. Optional CHECKSUM_EN adds frame_sum.
module lcd_cmd_driver #(
  parameter int unsigned DW          = 8,
  parameter int unsigned NPIX        = 64,
  parameter int unsigned NOUT        = 16,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          img_we,
  input  logic [5:0]    img_addr,
  input  logic [DW-1:0] img_data,
  input  logic          req_valid,
  input  logic [2:0]    req_cmd,
  output logic          req_ready,
  output logic [2:0]    lcd_cmd,
  output logic          lcd_cmd_valid,
  output logic [DW-1:0] lcd_datain,
  input  logic          lcd_busy,
  input  logic [DW-1:0] lcd_dataout,
  input  logic          lcd_output_valid,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic [3:0]    res_idx,
  output logic          frame_done,
  output logic          err_timeout
`ifdef CHECKSUM_EN
  ,
  output logic [DW+3:0] frame_sum
`endif
);

  localparam int unsigned PW = $clog2(NPIX);
  localparam int unsigned CW = $clog2(NOUT);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_WAIT_OUT  = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY = 3'd4;

  localparam logic [2:0]    CMD_LOAD = 3'd1;
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NOUT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_PRE  = TW'(TIMEOUT_CYC - 2);

  logic [DW-1:0] ram_q [NPIX];

  logic [2:0]    state_q, state_d;
  logic [2:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [DW-1:0] datain_q, datain_d;
  logic [PW-1:0] pix_q, pix_d, pix_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [3:0]    res_idx_q, res_idx_d;
  logic          frame_done_q, frame_done_d;
  logic          err_timeout_q, err_timeout_d;
`ifdef CHECKSUM_EN
  logic [DW+3:0] sum_q, sum_d;
`endif

  assign pix_nxt = pix_q + 1'b1;

  // Gated by reset so nothing is accepted while the block is held in reset
  assign req_ready = (state_q == S_IDLE) && !lcd_busy && !reset;

  always_ff @(posedge clk) begin
    if (img_we && state_q == S_IDLE) ram_q[img_addr] <= img_data;
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = 1'b0;
    datain_d      = datain_q;
    pix_d         = pix_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    res_valid_d   = 1'b0;
    res_data_d    = res_data_q;
    res_idx_d     = res_idx_q;
    frame_done_d  = 1'b0;
    err_timeout_d = 1'b0;
`ifdef CHECKSUM_EN
    sum_d         = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          cmd_d       = req_cmd;
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
`ifdef CHECKSUM_EN
          sum_d       = '0;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (cmd_q == CMD_LOAD) begin
          state_d  = S_LOAD;
          pix_d    = '0;
          datain_d = ram_q[0];
        end else begin
          state_d = S_WAIT_OUT;
        end
      end
      S_LOAD: begin
        if (pix_q == PIX_LAST) begin
          state_d = S_WAIT_OUT;
        end else begin
          pix_d    = pix_nxt;
          datain_d = ram_q[pix_nxt];
        end
      end
      S_WAIT_OUT, S_WAIT_BUSY: begin
        // err_timeout is raised one cycle early so the abort to IDLE lands right after the pulse
        if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (state_q == S_WAIT_OUT && lcd_output_valid) begin
          tmo_d       = '0;
          res_valid_d = 1'b1;
          res_data_d  = lcd_dataout;
          res_idx_d   = 4'(cnt_q);
`ifdef CHECKSUM_EN
          sum_d       = sum_q + (DW+4)'(lcd_dataout);
`endif
          if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            frame_done_d = 1'b1;
            state_d      = S_WAIT_BUSY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (state_q == S_WAIT_BUSY && !lcd_busy) begin
          state_d = S_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d         = tmo_q + 1'b1;
          err_timeout_d = (tmo_q == TMO_PRE);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      datain_q      <= '0;
      pix_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_idx_q     <= '0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      datain_q      <= datain_d;
      pix_q         <= pix_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_idx_q     <= res_idx_d;
      frame_done_q  <= frame_done_d;
      err_timeout_q <= err_timeout_d;
`ifdef CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = cmd_valid_q;
  assign lcd_datain    = datain_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_idx       = res_idx_q;
  assign frame_done    = frame_done_q;
  assign err_timeout   = err_timeout_q;
`ifdef CHECKSUM_EN
  assign frame_sum     = sum_q;
`endif

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Directed/randomized bench for lcd_cmd_driver; plays the LCD controller and models the
// expected pixel stream, results, timeout timing and (with CHECKSUM_EN) the frame sum.
module tb_lcd_cmd_driver;
  localparam int unsigned DW          = 8;
  localparam int unsigned NPIX        = 64;
  localparam int unsigned NOUT        = 16;
  localparam int unsigned TIMEOUT_CYC = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          img_we;
  logic [5:0]    img_addr;
  logic [DW-1:0] img_data;
  logic          req_valid;
  logic [2:0]    req_cmd;
  logic          req_ready;
  logic [2:0]    lcd_cmd;
  logic          lcd_cmd_valid;
  logic [DW-1:0] lcd_datain;
  logic          lcd_busy;
  logic [DW-1:0] lcd_dataout;
  logic          lcd_output_valid;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [3:0]    res_idx;
  logic          frame_done;
  logic          err_timeout;
`ifdef CHECKSUM_EN
  logic [DW+3:0] frame_sum;
`endif

  int unsigned   checks = 0;
  int unsigned   failures = 0;
  logic [DW-1:0] ram_m [NPIX];
  logic [DW-1:0] exp_datain;
  logic [DW-1:0] tp;
  logic          early;

  lcd_cmd_driver #(.DW(DW), .NPIX(NPIX), .NOUT(NOUT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset),
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
    .lcd_busy(lcd_busy), .lcd_dataout(lcd_dataout), .lcd_output_valid(lcd_output_valid),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .frame_done(frame_done), .err_timeout(err_timeout)
`ifdef CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmdv"}, lcd_cmd_valid, 0);
    chk({tag, "_cmd"}, lcd_cmd, 0);
    chk({tag, "_datain"}, lcd_datain, 0);
    chk({tag, "_resv"}, res_valid, 0);
    chk({tag, "_resd"}, res_data, 0);
    chk({tag, "_idx"}, res_idx, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_tmo"}, err_timeout, 0);
    chk({tag, "_ready"}, req_ready, 0);
`ifdef CHECKSUM_EN
    chk({tag, "_sum"}, frame_sum, 0);
`endif
  endtask

  task automatic write_ram(input int unsigned k, input logic [DW-1:0] d);
    img_we = 1'b1; img_addr = 6'(k); img_data = d;
    @(negedge clk);
    img_we = 1'b0;
    ram_m[k] = d;
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    chk_zero("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_datain = '0;
    #1;
    chk("rst_mid_release_ready", req_ready, 1);
  endtask

  // mode: 0 random pixels, 1 ramp 1..NOUT, 2 all ones
  task automatic do_frame(input logic [2:0] cmd, input int busy_cycles, input int mode,
                          input int abort_at, input int big_gap);
    logic [DW-1:0] pix;
    int unsigned   sum;
    int            gap;
    sum = 0;
    req_valid = 1'b1; req_cmd = cmd; lcd_busy = (busy_cycles > 0);
    for (int b = 0; b < busy_cycles; b++) begin
      #1;
      chk("ready_while_busy", req_ready, 0);
      @(negedge clk);
      chk("cmdv_while_busy", lcd_cmd_valid, 0);
    end
    lcd_busy = 1'b0;
    #1;
    chk("ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; req_cmd = 3'($urandom);
    chk("issue_cmdv", lcd_cmd_valid, 1);
    chk("issue_cmd", lcd_cmd, cmd);
    if (cmd == 3'd1) begin
      for (int k = 0; k < NPIX; k++) begin
        lcd_output_valid = 1'($urandom_range(0, 1));
        lcd_dataout = DW'($urandom);
        @(negedge clk);
        chk("load_datain", lcd_datain, ram_m[k]);
        chk("load_cmdv", lcd_cmd_valid, 0);
        chk("load_resv", res_valid, 0);
        if (k == abort_at) begin
          lcd_output_valid = 1'b0;
          mid_reset();
          return;
        end
      end
      exp_datain = ram_m[NPIX-1];
    end
    lcd_output_valid = 1'b0;
    @(negedge clk);
    chk("datain_hold", lcd_datain, exp_datain);
    chk("wait_resv", res_valid, 0);
    for (int i = 0; i < NOUT; i++) begin
      gap = (i == 7) ? big_gap : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        img_we = 1'b1; img_addr = 6'($urandom); img_data = DW'($urandom);
        @(negedge clk);
        chk("gap_resv", res_valid, 0);
      end
      img_we = 1'b0;
      pix = (mode == 0) ? DW'($urandom) : (mode == 1) ? DW'(i + 1) : '1;
      lcd_output_valid = 1'b1; lcd_dataout = pix;
      @(negedge clk);
      lcd_output_valid = 1'b0;
      chk("res_valid", res_valid, 1);
      chk("res_data", res_data, pix);
      chk("res_idx", res_idx, i);
      chk("frame_done", frame_done, (i == NOUT - 1));
      chk("no_timeout", err_timeout, 0);
      sum += pix;
    end
`ifdef CHECKSUM_EN
    chk("frame_sum", frame_sum, sum);
`endif
    lcd_busy = 1'b1;
    @(negedge clk);
    chk("fd_pulse_end", frame_done, 0);
    chk("ready_wait_busy", req_ready, 0);
`ifdef CHECKSUM_EN
    chk("frame_sum_held", frame_sum, sum);
`endif
    lcd_busy = 1'b0;
    @(negedge clk);
    chk("ready_after_frame", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; img_we = 1'b0; img_addr = '0; img_data = '0;
    req_valid = 1'b0; req_cmd = '0; lcd_busy = 1'b0; lcd_dataout = '0;
    lcd_output_valid = 1'b0; exp_datain = '0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    #1;
    chk("rst_release_ready", req_ready, 1);

    for (int k = 0; k < NPIX; k++) write_ram(k, DW'(k));
    do_frame(3'd1, 0, 0, -1, 0);
    do_frame(3'd4, 3, 1, -1, 0);
    do_frame(3'd0, 0, 2, -1, 200);

    // timeout: three pixels then silence; abort 256 cycles after the last pixel cycle
    req_valid = 1'b1; req_cmd = 3'd2;
    #1;
    chk("tmo_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("tmo_cmdv", lcd_cmd_valid, 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tp = DW'($urandom);
      lcd_output_valid = 1'b1; lcd_dataout = tp;
      @(negedge clk);
      chk("tmo_resd", res_data, tp);
      chk("tmo_idx", res_idx, i);
    end
    lcd_output_valid = 1'b0;
    early = 1'b0;
    for (int c = 5; c <= 258; c++) begin
      @(negedge clk);
      early = early | err_timeout | res_valid;
    end
    chk("tmo_early", early, 0);
    @(negedge clk);
    chk("tmo_pulse", err_timeout, 1);
    chk("tmo_ready_during", req_ready, 0);
    @(negedge clk);
    chk("tmo_pulse_end", err_timeout, 0);
    chk("tmo_ready_after", req_ready, 1);
    chk("tmo_datain_hold", lcd_datain, exp_datain);

    for (int k = 0; k < NPIX; k++) write_ram(k, DW'($urandom));
    do_frame(3'd1, 0, 0, 9, 0);
    do_frame(3'd1, 0, 0, -1, 0);
    for (int n = 0; n < 4; n++) begin
      do_frame(3'($urandom), int'($urandom_range(0, 2)), 0, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
